// File: rtl/volume_ramp_pkg.sv
// Shared types and helpers for the volume_ramp block.
// Gain values are unsigned with unity at 2^(GAIN_WIDTH-2).
package volume_ramp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StOut
    } vr_state_e;

    function automatic int unsigned unity_gain(input int unsigned gain_width);
        return 32'd1 << (gain_width - 2);
    endfunction

    // Limits one ramp increment so the gain can never overshoot its target.
    function automatic int clamp_step(input int diff, input int step);
        if (diff > step) begin
            return step;
        end else if (diff < -step) begin
            return -step;
        end
        return diff;
    endfunction

endpackage

// File: rtl/vr_sat_mult.sv
// Sample x gain multiply with arithmetic rescale, range check and output limiting.
// Define VOLUME_RAMP_SATURATE_EN to saturate out-of-range results; otherwise they wrap.
module vr_sat_mult #(
    parameter int unsigned INPUT_WIDTH = 24,
    parameter int unsigned GAIN_WIDTH  = 16
) (
    input  logic signed [INPUT_WIDTH-1:0] din,
    input  logic        [GAIN_WIDTH-1:0]  gain,
    output logic        [INPUT_WIDTH-1:0] dout,
    output logic                          ovf
);

    localparam int unsigned PW = INPUT_WIDTH + GAIN_WIDTH + 1;

    localparam logic signed [PW-1:0] SMAX = {{(GAIN_WIDTH + 2){1'b0}}, {(INPUT_WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(GAIN_WIDTH + 2){1'b1}}, {(INPUT_WIDTH - 1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic                 too_high;
    logic                 too_low;

    always_comb begin
        prod     = PW'(din) * PW'($signed({1'b0, gain}));
        shifted  = prod >>> (GAIN_WIDTH - 2);
        too_high = shifted > SMAX;
        too_low  = shifted < SMIN;
        ovf      = too_high | too_low;
`ifdef VOLUME_RAMP_SATURATE_EN
        // Negative limit is symmetric with the positive one, not the most negative code.
        if (too_high) begin
            dout = SMAX[INPUT_WIDTH-1:0];
        end else if (too_low) begin
            dout = {1'b1, {(INPUT_WIDTH - 2){1'b0}}, 1'b1};
        end else begin
            dout = shifted[INPUT_WIDTH-1:0];
        end
`else
        dout = shifted[INPUT_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/volume_ramp.sv
// Per-channel ramped volume control over a time-multiplexed sample stream.
// Optional VOLUME_RAMP_SATURATE_EN selects saturation instead of wrap in vr_sat_mult.
module volume_ramp
    import volume_ramp_pkg::*;
#(
    parameter int unsigned NR_CHANNELS = 3,
    parameter int unsigned INPUT_WIDTH = 24,
    parameter int unsigned GAIN_WIDTH  = 16,
    parameter int unsigned RAMP_STEP   = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [INPUT_WIDTH-1:0]  s_vr_d,
    input  logic [$clog2(NR_CHANNELS)-1:0] s_vr_ch,
    input  logic                           s_vr_dv,
    output logic                           s_vr_dr,
    output logic        [INPUT_WIDTH-1:0]  m_vr_d,
    output logic [$clog2(NR_CHANNELS)-1:0] m_vr_ch,
    output logic                           m_vr_dv,
    input  logic                           m_vr_dr,
    input  logic        [GAIN_WIDTH-1:0]   gain,
    input  logic [$clog2(NR_CHANNELS)-1:0] gain_ch,
    input  logic                           gain_wr,
    input  logic                           mute,
    output logic                           ramp_active,
    output logic                           overflow
);

    localparam int unsigned CW = $clog2(NR_CHANNELS);
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(GAIN_WIDTH));

    vr_state_e                       state_q, state_d;
    logic signed [INPUT_WIDTH-1:0]   in_d_q, in_d_d;
    logic [CW-1:0]                   in_ch_q, in_ch_d;
    logic [INPUT_WIDTH-1:0]          out_d_q, out_d_d;
    logic [CW-1:0]                   out_ch_q, out_ch_d;
    logic                            out_dv_q, out_dv_d;
    logic                            ovf_q, ovf_d;
    logic                            ramp_active_q, ramp_active_d;
    logic [GAIN_WIDTH-1:0]           cur_gain_q [NR_CHANNELS];
    logic [GAIN_WIDTH-1:0]           cur_gain_d [NR_CHANNELS];
    logic [GAIN_WIDTH-1:0]           tgt_gain_q [NR_CHANNELS];
    logic [GAIN_WIDTH-1:0]           tgt_gain_d [NR_CHANNELS];
    logic [GAIN_WIDTH-1:0]           eff_tgt    [NR_CHANNELS];
    logic [GAIN_WIDTH-1:0]           sel_gain;
    logic [INPUT_WIDTH-1:0]          mult_d;
    logic                            mult_ovf;

    function automatic logic [GAIN_WIDTH-1:0] ramp_gain(input logic [GAIN_WIDTH-1:0] cur,
                                                        input logic [GAIN_WIDTH-1:0] tgt);
        int c;
        int t;
        c = int'(cur);
        t = int'(tgt);
        return GAIN_WIDTH'(c + clamp_step(t - c, int'(RAMP_STEP)));
    endfunction

    vr_sat_mult #(
        .INPUT_WIDTH(INPUT_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_mult (
        .din (in_d_q),
        .gain(sel_gain),
        .dout(mult_d),
        .ovf (mult_ovf)
    );

    always_comb begin
        state_d       = state_q;
        in_d_d        = in_d_q;
        in_ch_d       = in_ch_q;
        out_d_d       = out_d_q;
        out_ch_d      = out_ch_q;
        out_dv_d      = out_dv_q;
        ovf_d         = ovf_q;
        sel_gain      = '0;
        ramp_active_d = 1'b0;

        for (int i = 0; i < int'(NR_CHANNELS); i++) begin
            eff_tgt[i]    = mute ? '0 : tgt_gain_q[i];
            cur_gain_d[i] = cur_gain_q[i];
            tgt_gain_d[i] = tgt_gain_q[i];
            if (gain_wr && gain_ch == CW'(i)) begin
                tgt_gain_d[i] = gain;
            end
            if (in_ch_q == CW'(i)) begin
                sel_gain = cur_gain_q[i];
            end
            if (cur_gain_q[i] != eff_tgt[i]) begin
                ramp_active_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                // Out-of-range channels are consumed but never processed.
                if (s_vr_dv && 32'(s_vr_ch) < NR_CHANNELS) begin
                    in_d_d  = s_vr_d;
                    in_ch_d = s_vr_ch;
                    state_d = StMult;
                end
            end
            StMult: begin
                out_d_d  = mult_d;
                ovf_d    = mult_ovf;
                out_ch_d = in_ch_q;
                out_dv_d = 1'b1;
                state_d  = StOut;
                // Product above already used the pre-update gain; target is the registered one.
                for (int i = 0; i < int'(NR_CHANNELS); i++) begin
                    if (in_ch_q == CW'(i)) begin
                        cur_gain_d[i] = ramp_gain(cur_gain_q[i], eff_tgt[i]);
                    end
                end
            end
            StOut: begin
                if (m_vr_dr) begin
                    out_dv_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            in_d_q        <= '0;
            in_ch_q       <= '0;
            out_d_q       <= '0;
            out_ch_q      <= '0;
            out_dv_q      <= 1'b0;
            ovf_q         <= 1'b0;
            ramp_active_q <= 1'b0;
            for (int i = 0; i < int'(NR_CHANNELS); i++) begin
                cur_gain_q[i] <= '0;
                tgt_gain_q[i] <= UNITY;
            end
        end else begin
            state_q       <= state_d;
            in_d_q        <= in_d_d;
            in_ch_q       <= in_ch_d;
            out_d_q       <= out_d_d;
            out_ch_q      <= out_ch_d;
            out_dv_q      <= out_dv_d;
            ovf_q         <= ovf_d;
            ramp_active_q <= ramp_active_d;
            for (int i = 0; i < int'(NR_CHANNELS); i++) begin
                cur_gain_q[i] <= cur_gain_d[i];
                tgt_gain_q[i] <= tgt_gain_d[i];
            end
        end
    end

    assign s_vr_dr     = (state_q == StIdle) && !rst;
    assign m_vr_d      = out_d_q;
    assign m_vr_ch     = out_ch_q;
    assign m_vr_dv     = out_dv_q;
    assign overflow    = ovf_q;
    assign ramp_active = ramp_active_q;

endmodule

// File: tb/tb_volume_ramp.sv
// Directed bench for volume_ramp: fade-in, mute reversal, overflow, backpressure, reset.
module tb_volume_ramp;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [23:0] s_vr_d;
    logic [1:0]         s_vr_ch;
    logic               s_vr_dv;
    logic               s_vr_dr;
    logic [23:0]        m_vr_d;
    logic [1:0]         m_vr_ch;
    logic               m_vr_dv;
    logic               m_vr_dr;
    logic [15:0]        gain;
    logic [1:0]         gain_ch;
    logic               gain_wr;
    logic               mute;
    logic               ramp_active;
    logic               overflow;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [23:0] din;
        logic [23:0] exp;
        logic        ovf;
    } vec_t;

    vec_t tbl [9];

    volume_ramp dut (
        .clk        (clk),
        .rst        (rst),
        .s_vr_d     (s_vr_d),
        .s_vr_ch    (s_vr_ch),
        .s_vr_dv    (s_vr_dv),
        .s_vr_dr    (s_vr_dr),
        .m_vr_d     (m_vr_d),
        .m_vr_ch    (m_vr_ch),
        .m_vr_dv    (m_vr_dv),
        .m_vr_dr    (m_vr_dr),
        .gain       (gain),
        .gain_ch    (gain_ch),
        .gain_wr    (gain_wr),
        .mute       (mute),
        .ramp_active(ramp_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%06h, expected 0x%06h", name, act, exp);
        end
    endtask

    task automatic drive_in(input logic [1:0] ch, input logic [23:0] d);
        int n = 0;
        s_vr_d  = d;
        s_vr_ch = ch;
        s_vr_dv = 1'b1;
        while (!s_vr_dr && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_vr_dr) check("in_ready_timeout", {23'd0, s_vr_dr}, 24'd1);
        @(posedge clk); #1;
        s_vr_dv = 1'b0;
    endtask

    task automatic wait_out(output logic [23:0] d, output logic [1:0] ch, output logic ovf);
        int n = 0;
        while (!m_vr_dv && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_vr_dv) check("out_valid_timeout", {23'd0, m_vr_dv}, 24'd1);
        d   = m_vr_d;
        ch  = m_vr_ch;
        ovf = overflow;
        if (m_vr_dr) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic xfer(input string name, input logic [1:0] ch, input logic [23:0] d,
                        input logic [23:0] exp, input logic exp_ovf);
        logic [23:0] od;
        logic [1:0]  och;
        logic        oo;
        drive_in(ch, d);
        wait_out(od, och, oo);
        check(name, od, exp);
        check({name, "_ch"}, {22'd0, och}, {22'd0, ch});
        check({name, "_ovf"}, {23'd0, oo}, {23'd0, exp_ovf});
    endtask

    task automatic wr_gain(input logic [1:0] ch, input logic [15:0] g);
        gain    = g;
        gain_ch = ch;
        gain_wr = 1'b1;
        @(posedge clk); #1;
        gain_wr = 1'b0;
    endtask

    initial begin
        logic [23:0] od;
        logic [1:0]  och;
        logic        oo;
        int          g;

        tbl[0] = '{2'd0, 24'hFFFFFF, 24'hFFFFFF, 1'b0};
        tbl[1] = '{2'd0, 24'h000003, 24'h000001, 1'b0};
        tbl[2] = '{2'd0, 24'hFFFFFD, 24'hFFFFFE, 1'b0};
        tbl[3] = '{2'd0, 24'h7FFFFF, 24'h3FFFFF, 1'b0};
        tbl[4] = '{2'd0, 24'h800000, 24'hC00000, 1'b0};
        tbl[5] = '{2'd1, 24'h123456, 24'h123456, 1'b0};
        tbl[6] = '{2'd2, 24'hFFFFFB, 24'hFFFFFB, 1'b0};
        tbl[7] = '{2'd1, 24'h7FFFFF, 24'h7FFFFF, 1'b0};
        tbl[8] = '{2'd2, 24'h800000, 24'h800000, 1'b0};

        rst = 1'b1; s_vr_d = '0; s_vr_ch = '0; s_vr_dv = 1'b0; m_vr_dr = 1'b1;
        gain = '0; gain_ch = '0; gain_wr = 1'b0; mute = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {23'd0, s_vr_dr}, 24'd0);
        check("rst_out_valid", {23'd0, m_vr_dv}, 24'd0);
        check("rst_out_data", m_vr_d, 24'd0);
        check("rst_overflow", {23'd0, overflow}, 24'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ramp_after_rst", {23'd0, ramp_active}, 24'd1);

        // Fade-in from gain 0 to unity on all three channels.
        for (int k = 0; k <= 256; k++) begin
            for (int c = 0; c < 3; c++) begin
                xfer("fade_in", 2'(c), 24'h100000, 24'(k * 4096), 1'b0);
            end
            if (k == 10) check("ramp_mid_fade", {23'd0, ramp_active}, 24'd1);
        end
        check("ramp_done_fade", {23'd0, ramp_active}, 24'd0);

        // Ramp ch0 down to 0.5.
        wr_gain(2'd0, 16'd8192);
        for (int j = 0; j < 128; j++) begin
            xfer("ch0_to_half", 2'd0, 24'h100000, 24'((16384 - 64 * j) * 64), 1'b0);
        end

        // Invalid channel is swallowed.
        s_vr_d = 24'h111111; s_vr_ch = 2'd3; s_vr_dv = 1'b1;
        @(posedge clk); #1;
        s_vr_dv = 1'b0;
        check("drop_ready", {23'd0, s_vr_dr}, 24'd1);
        repeat (3) begin
            @(posedge clk); #1;
            check("drop_no_out", {23'd0, m_vr_dv}, 24'd0);
        end

        for (int i = 0; i < 9; i++) begin
            xfer($sformatf("tbl%0d", i), tbl[i].ch, tbl[i].din, tbl[i].exp, tbl[i].ovf);
        end

        // ch1 ramps to 2.0, then overflows.
        wr_gain(2'd1, 16'd32768);
        for (int j = 0; j < 256; j++) begin
            xfer("ch1_to_two", 2'd1, 24'h000100, 24'(256 + j), 1'b0);
        end
`ifdef VOLUME_RAMP_SATURATE_EN
        xfer("ovf_pos", 2'd1, 24'h600000, 24'h7FFFFF, 1'b1);
        xfer("ovf_neg", 2'd1, 24'hA00000, 24'h800001, 1'b1);
`else
        xfer("ovf_pos", 2'd1, 24'h600000, 24'hC00000, 1'b1);
        xfer("ovf_neg", 2'd1, 24'hA00000, 24'h400000, 1'b1);
`endif
        xfer("ovf_ch0_ok", 2'd0, 24'h000100, 24'h000080, 1'b0);
        xfer("ovf_ch2_ok", 2'd2, 24'h000100, 24'h000100, 1'b0);

        // Backpressure: output held for 10 cycles.
        m_vr_dr = 1'b0;
        drive_in(2'd1, 24'h001000);
        wait_out(od, och, oo);
        check("stall_first", od, 24'h002000);
        repeat (10) begin
            @(posedge clk); #1;
            check("stall_d", m_vr_d, 24'h002000);
            check("stall_ch", {22'd0, m_vr_ch}, 24'd1);
            check("stall_dv", {23'd0, m_vr_dv}, 24'd1);
            check("stall_in_ready", {23'd0, s_vr_dr}, 24'd0);
        end
        m_vr_dr = 1'b1;
        @(posedge clk); #1;
        check("stall_release", {23'd0, m_vr_dv}, 24'd0);
        check("stall_ready_back", {23'd0, s_vr_dr}, 24'd1);
        xfer("after_stall", 2'd1, 24'h000800, 24'h001000, 1'b0);

        // Mute on ch2, reversed after 99 samples.
        mute = 1'b1;
        for (int j = 0; j < 99; j++) begin
            xfer("mute_down", 2'd2, 24'h100000, 24'((16384 - 64 * j) * 64), 1'b0);
        end
        check("ramp_muted", {23'd0, ramp_active}, 24'd1);
        mute = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            g = 10048 + 64 * k;
            if (g > 16384) g = 16384;
            xfer("unmute_up", 2'd2, 24'h100000, 24'(g * 64), 1'b0);
        end

        // Target write lands in the MULT cycle of a ch2 sample.
        drive_in(2'd2, 24'h100000);
        wr_gain(2'd2, 16'd0);
        wait_out(od, och, oo);
        check("wr_in_mult", od, 24'h100000);
        xfer("wr_next1", 2'd2, 24'h100000, 24'h100000, 1'b0);
        xfer("wr_next2", 2'd2, 24'h100000, 24'h0FF000, 1'b0);

        // Reset while a sample waits in OUT.
        m_vr_dr = 1'b0;
        drive_in(2'd1, 24'h001000);
        wait_out(od, och, oo);
        check("rst_pending_valid", {23'd0, m_vr_dv}, 24'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_dv", {23'd0, m_vr_dv}, 24'd0);
        check("rst_mid_ready", {23'd0, s_vr_dr}, 24'd0);
        check("rst_mid_d", m_vr_d, 24'd0);
        rst = 1'b0;
        m_vr_dr = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("rst_no_emit", {23'd0, m_vr_dv}, 24'd0);
        end
        check("rst_ramp_again", {23'd0, ramp_active}, 24'd1);
        xfer("rst_gain_zero", 2'd1, 24'h100000, 24'h000000, 1'b0);
        xfer("rst_gain_step", 2'd1, 24'h100000, 24'h001000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
